mul_div_unit: RTL and testbench

Iterative multiply/divide unit that consumes the two register-file read operands (RD1 → a, RD2 → b) and produces the HI/LO results used by MULT/MULTU/DIV/DIVU and read back by MFHI/MFLO. It sits directly downstream of the register file, beside the ALU in the execute stage. The controller stalls the PC while `busy` is high.

---
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit producing HI/LO, with MTHI/MTLO write-back.
// Divider datapath and ops 10/11 are compiled in only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] hi_q, lo_q, hi_fix, lo_fix;
  logic [31:0] acc_q, acc_d, mpl_q, mpl_d, opnd_q;
  logic        sign_a_q, sign_b_q;
  logic        accept, op_ok, signed_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod;
`ifdef MUL_DIV_UNIT_DIV_EN
  logic        is_div_q, bzero_q;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
`endif

  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

`ifdef MUL_DIV_UNIT_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign accept    = start && (state_q == IDLE) && op_ok;
  assign signed_op = ~op[0];
  assign sign_a    = signed_op & a[31];
  assign sign_b    = signed_op & b[31];
  assign mag_a     = sign_a ? abs32(a) : a;
  assign mag_b     = sign_b ? abs32(b) : b;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept)                 cnt_q <= '0;
      else if (state_q == CALC)   cnt_q <= cnt_q + 6'd1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: registered outputs
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  // Both ops share {acc, mpl}: acc is the running product high half / remainder,
  // mpl is the multiplier / dividend that turns into the quotient.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, opnd_q} : 33'd0);
    acc_d   = mul_sum[32:1];
    mpl_d   = {mul_sum[0], mpl_q[31:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
    div_shift = {acc_q, mpl_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (is_div_q) begin
      if (!div_diff[33]) begin
        acc_d = div_diff[31:0];
        mpl_d = {mpl_q[30:0], 1'b1};
      end else begin
        acc_d = div_shift[31:0];
        mpl_d = {mpl_q[30:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= '0;
      mpl_q    <= mag_a;
      opnd_q   <= mag_b;
      sign_a_q <= sign_a;
      sign_b_q <= sign_b;
`ifdef MUL_DIV_UNIT_DIV_EN
      is_div_q <= op[1];
      bzero_q  <= (b == 32'd0);
`endif
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      mpl_q <= mpl_d;
    end
  end

  // Sign fix-up; a zero divisor leaves the magnitude of a as remainder, so HI = a already.
  always_comb begin
    prod   = neg64({acc_q, mpl_q}, sign_a_q ^ sign_b_q);
    hi_fix = prod[63:32];
    lo_fix = prod[31:0];
`ifdef MUL_DIV_UNIT_DIV_EN
    if (is_div_q) begin
      hi_fix = neg32(acc_q, sign_a_q);
      lo_fix = bzero_q ? 32'hFFFF_FFFF : neg32(mpl_q, sign_a_q ^ sign_b_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FIX) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end else if (state_q == IDLE && !accept) begin
      if (hi_we) hi_q <= wd;
      if (lo_we) lo_q <= wd;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: drivers queue expected HI/LO, a monitor checks on done.
module tb_mul_div_unit;

  logic        clk, rst_n;
  logic [31:0] a, b, wd;
  logic [1:0]  op;
  logic        start, hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [31:0] cur_hi, cur_lo;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hi(hi), .lo(lo),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("latency", 32'(cyc - e.cyc), 32'd33);
      end
    end
  end

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    if (done !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Launch an op and queue its result; b2b launches in the current (done) cycle.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [31:0] eh, input logic [31:0] el,
                       input bit b2b);
    exp_t e;
    if (!b2b) @(negedge clk);
    op = o; a = xa; b = xb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hX; b = 32'hX;
    e.hi = eh; e.lo = el; e.cyc = cyc;
    sb.push_back(e);
    cur_hi = eh; cur_lo = el;
    wait_done(name);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = '0; b = '0; op = '0; wd = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);

    // MTLO alone, then MTHI+MTLO together
    @(negedge clk);
    lo_we = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi", hi, 32'hFFFF_FFFF);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", hi, 32'hA5A5_0F0F);
    check("mtboth_lo", lo, 32'hA5A5_0F0F);

    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);

`ifdef MUL_DIV_UNIT_DIV_EN
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    do_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
`else
    begin
      logic seen_busy;
      seen_busy = 1'b0;
      @(negedge clk);
      op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (busy !== 1'b0) seen_busy = 1'b1;
        @(negedge clk);
      end
      check("nodiv_busy", {31'd0, seen_busy}, 32'd0);
      check("nodiv_hi", hi, cur_hi);
      check("nodiv_lo", lo, cur_lo);
    end
`endif
    do_op("multu_small", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 0);

    // Second start and MTHI mid-CALC must be ignored
    begin
      exp_t e;
      @(negedge clk);
      op = 2'b01; a = 32'h0001_0001; b = 32'h0001_0001; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.hi = 32'h0000_0001; e.lo = 32'h0002_0001; e.cyc = cyc;
      sb.push_back(e);
      repeat (5) @(negedge clk);
      op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      check("midcalc_hi_hold", hi, cur_hi);
      check("midcalc_busy", {31'd0, busy}, 32'd1);
      wait_done("midcalc");
      cur_hi = e.hi; cur_lo = e.lo;
    end

    // Reset mid-CALC aborts with no done
    @(negedge clk);
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_hi_after", hi, 32'd0);
    check("pending_results", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
